// File: rtl/bpc_defs_pkg.sv
// Shared definitions for the N-channel button press counter:
// FSM state encoding and width helper functions.
package bpc_defs_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_e;

    // Ceiling log2; returns 0 for values of 0 or 1
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Per-press increment is weight field + 1, which needs one extra bit
    function automatic int unsigned inc_width(input int unsigned weight_w);
        return weight_w + 1;
    endfunction

endpackage

// File: rtl/bpc_channel.sv
// One button channel: input history, rising-edge detect, weighted
// increment and the per-channel counter with saturate/wrap overflow.
module bpc_channel
    import bpc_defs_pkg::*;
#(
    parameter int unsigned COUNT_W  = 8,
    parameter int unsigned WEIGHT_W = 2,
    parameter int unsigned SATURATE = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_count_en,
    input  logic                          i_button,
    input  logic [WEIGHT_W-1:0]           i_weight,
    output logic                          o_press_c,
    output logic [inc_width(WEIGHT_W)-1:0] o_inc_c,
    output logic [COUNT_W-1:0]            o_count,
    output logic                          o_ovf_c
);

    localparam int unsigned INC_W = inc_width(WEIGHT_W);
    localparam int unsigned SUM_W = COUNT_W + 1;

    logic               r_btn_q;
    logic [COUNT_W-1:0] r_count;
    logic [SUM_W-1:0]   w_sum;
    logic               w_hit;
    logic               w_clamp;

    assign o_press_c = i_button & ~r_btn_q;
    assign o_inc_c   = INC_W'(i_weight) + INC_W'(1);
    assign w_sum     = SUM_W'(r_count) + SUM_W'(o_inc_c);
    assign w_hit     = i_count_en & o_press_c;
    assign o_ovf_c   = w_hit & w_sum[COUNT_W];
    assign w_clamp   = (SATURATE != 0) && w_sum[COUNT_W];
    assign o_count   = r_count;

    // History tracks the button in every state so a level held at
    // session entry is never seen as a fresh press
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_q <= 1'b0;
            r_count <= '0;
        end else begin
            r_btn_q <= i_button;
            if (!i_count_en) begin
                r_count <= '0;
            end else if (w_hit) begin
                r_count <= w_clamp ? '1 : w_sum[COUNT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/button_press_counter_n.sv
// N-channel weighted button press counter: session FSM, total counter,
// sticky overflow, display select and thermometer indicator.
module button_press_counter_n
    import bpc_defs_pkg::*;
#(
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned COUNT_W  = 8,
    parameter int unsigned WEIGHT_W = 2,
    parameter int unsigned IND_W    = 10,
    parameter int unsigned IND_STEP = 25,
    parameter int unsigned SATURATE = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             activator,
    input  logic [CHANNELS-1:0]              buttons,
    input  logic [CHANNELS*WEIGHT_W-1:0]     equalizer,
    input  logic [clog2(CHANNELS+1)-1:0]     view_sel,
    output logic [COUNT_W-1:0]               display,
    output logic [IND_W-1:0]                 indicator,
    output logic                             overflow,
    output logic                             active
);

    localparam int unsigned INC_W  = inc_width(WEIGHT_W);
    localparam int unsigned ADD_W  = INC_W + clog2(CHANNELS);
    localparam int unsigned SUM_W  = COUNT_W + 1;
    localparam int unsigned VSEL_W = clog2(CHANNELS + 1);
    localparam int unsigned CMP_W  = 32;

    state_e                            r_state;
    logic [COUNT_W-1:0]                r_total;
    logic                              r_overflow;

    logic                              w_count_en;
    logic [CHANNELS-1:0]               w_press;
    logic [CHANNELS-1:0][INC_W-1:0]    w_inc;
    logic [CHANNELS-1:0][COUNT_W-1:0]  w_ch_count;
    logic [CHANNELS-1:0]               w_ch_ovf;
    logic [ADD_W-1:0]                  w_add;
    logic [SUM_W-1:0]                  w_total_sum;
    logic                              w_total_ovf;
    logic [COUNT_W-1:0]                w_display;

    // Counting happens only on edges where the FSM is already in COUNT and
    // the activator is still high; any other edge clears the session
    assign w_count_en = (r_state == ST_COUNT) & activator;

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            bpc_channel #(
                .COUNT_W  (COUNT_W),
                .WEIGHT_W (WEIGHT_W),
                .SATURATE (SATURATE)
            ) u_ch (
                .clk        (clk),
                .rst        (rst),
                .i_count_en (w_count_en),
                .i_button   (buttons[i]),
                .i_weight   (equalizer[i*WEIGHT_W +: WEIGHT_W]),
                .o_press_c  (w_press[i]),
                .o_inc_c    (w_inc[i]),
                .o_count    (w_ch_count[i]),
                .o_ovf_c    (w_ch_ovf[i])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (activator)  r_state <= ST_COUNT;
                ST_COUNT: if (!activator) r_state <= ST_IDLE;
                default:                  r_state <= ST_IDLE;
            endcase
        end
    end

    // Sum of increments for every channel pressed this cycle
    always_comb begin
        w_add = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (w_press[i]) begin
                w_add = w_add + ADD_W'(w_inc[i]);
            end
        end
    end

    assign w_total_sum = SUM_W'(r_total) + SUM_W'(w_add);
    assign w_total_ovf = w_count_en & w_total_sum[COUNT_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_total    <= '0;
            r_overflow <= 1'b0;
        end else if (!w_count_en) begin
            r_total    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_total_ovf) begin
                r_total <= (SATURATE != 0) ? '1 : w_total_sum[COUNT_W-1:0];
            end else begin
                r_total <= w_total_sum[COUNT_W-1:0];
            end
            if ((|w_ch_ovf) | w_total_ovf) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Out-of-range selects fall through to the total
    always_comb begin
        w_display = r_total;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (view_sel == VSEL_W'(i)) begin
                w_display = w_ch_count[i];
            end
        end
    end

    generate
        for (genvar k = 0; k < IND_W; k++) begin : g_ind
            assign indicator[k] = CMP_W'(r_total) >= CMP_W'((k + 1) * IND_STEP);
        end
    endgenerate

    assign display  = w_display;
    assign overflow = r_overflow;
    assign active   = (r_state == ST_COUNT);

endmodule

// File: tb/tb_button_press_counter_n.sv
// Bench for button_press_counter_n: saturating and wrapping instances
// driven in lockstep and compared against an integer reference model.
module tb_button_press_counter_n;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        activator = 1'b0;
    logic [2:0]  buttons = 3'b000;
    logic [5:0]  equalizer = 6'b000000;
    logic [1:0]  view_sel = 2'd3;

    logic [7:0]  disp_s, disp_w;
    logic [9:0]  ind_s, ind_w;
    logic        ovf_s, ovf_w, act_s, act_w;

    int n_cmp = 0;
    int n_bad = 0;

    int m_ch[2][3];
    int m_tot[2];
    bit m_ovf[2];
    bit m_act;
    bit [2:0] m_prev;

    always #10 clk = ~clk;

    button_press_counter_n #(.SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst), .activator(activator), .buttons(buttons),
        .equalizer(equalizer), .view_sel(view_sel), .display(disp_s),
        .indicator(ind_s), .overflow(ovf_s), .active(act_s)
    );

    button_press_counter_n #(.SATURATE(0)) dut_wrap (
        .clk(clk), .rst(rst), .activator(activator), .buttons(buttons),
        .equalizer(equalizer), .view_sel(view_sel), .display(disp_w),
        .indicator(ind_w), .overflow(ovf_w), .active(act_w)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Add inc to a value; mode 0 clamps at 255, mode 1 wraps mod 256
    function automatic int bump(input int m, input int v, input int inc);
        int nv;
        nv = v + inc;
        if (nv > 255) begin
            m_ovf[m] = 1'b1;
            nv = (m == 0) ? 255 : nv - 256;
        end
        return nv;
    endfunction

    function automatic void model_edge();
        int inc;
        int add;
        if (rst) begin
            for (int m = 0; m < 2; m++) begin
                for (int i = 0; i < 3; i++) m_ch[m][i] = 0;
                m_tot[m] = 0;
                m_ovf[m] = 1'b0;
            end
            m_act  = 1'b0;
            m_prev = 3'b000;
            return;
        end
        for (int m = 0; m < 2; m++) begin
            if (m_act && activator) begin
                add = 0;
                for (int i = 0; i < 3; i++) begin
                    if (buttons[i] && !m_prev[i]) begin
                        inc = int'(equalizer[2*i +: 2]) + 1;
                        m_ch[m][i] = bump(m, m_ch[m][i], inc);
                        add += inc;
                    end
                end
                m_tot[m] = bump(m, m_tot[m], add);
            end else begin
                for (int i = 0; i < 3; i++) m_ch[m][i] = 0;
                m_tot[m] = 0;
                m_ovf[m] = 1'b0;
            end
        end
        m_act  = activator;
        m_prev = buttons;
    endfunction

    function automatic int exp_disp(input int m, input int vs);
        return (vs < 3) ? m_ch[m][vs] : m_tot[m];
    endfunction

    function automatic int exp_ind(input int m);
        int r;
        r = 0;
        for (int k = 0; k < 10; k++) begin
            if (m_tot[m] >= (k + 1) * 25) r |= (1 << k);
        end
        return r;
    endfunction

    // Full model comparison; leaves view_sel at 3 (total)
    task automatic check_all();
        for (int vs = 0; vs < 4; vs++) begin
            view_sel = 2'(vs);
            #1;
            chk("disp_sat", disp_s, exp_disp(0, vs));
            chk("disp_wrap", disp_w, exp_disp(1, vs));
        end
        chk("ind_sat", ind_s, exp_ind(0));
        chk("ind_wrap", ind_w, exp_ind(1));
        chk("ovf_sat", ovf_s, m_ovf[0]);
        chk("ovf_wrap", ovf_w, m_ovf[1]);
        chk("act_sat", act_s, m_act);
        chk("act_wrap", act_w, m_act);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic peek(input logic [1:0] vs);
        view_sel = vs;
        #1;
    endtask

    task automatic press_release(input logic [2:0] b);
        buttons = b;
        tick();
        buttons = 3'b000;
        tick();
    endtask

    initial begin
        // Reset
        tick();
        chk("rst_disp", disp_s, 0);
        chk("rst_ind", ind_s, 0);
        chk("rst_ovf", ovf_s, 0);
        chk("rst_act", act_s, 0);

        // Separate weighted presses on ch0 and ch1
        rst = 1'b0; activator = 1'b1;
        tick();
        equalizer = 6'b00_00_00; press_release(3'b001);
        equalizer = 6'b00_11_00; press_release(3'b010);
        peek(2'd0); chk("plan_ch0", disp_s, 1);
        peek(2'd1); chk("plan_ch1", disp_s, 4);
        peek(2'd3); chk("plan_total", disp_s, 5);
        chk("plan_ind", ind_s, 0);

        // Simultaneous presses with weights 2/3/4
        equalizer = 6'b11_10_01; buttons = 3'b111;
        tick();
        peek(2'd3); chk("simul_total", disp_s, 14);
        peek(2'd0); chk("simul_ch0", disp_s, 3);
        peek(2'd1); chk("simul_ch1", disp_s, 7);
        peek(2'd2); chk("simul_ch2", disp_s, 4);

        // Held button counts once per rising edge
        buttons = 3'b000; activator = 1'b0;
        tick();
        chk("drop_act", act_s, 0);
        chk("drop_disp", disp_s, 0);
        activator = 1'b1; equalizer = 6'b000000;
        tick();
        buttons = 3'b100;
        repeat (20) tick();
        buttons = 3'b000; tick();
        buttons = 3'b100; tick();
        peek(2'd2); chk("hold_ch2", disp_s, 2);
        buttons = 3'b000; tick();

        // 64 presses of weight 4: saturate vs wrap
        activator = 1'b0; tick();
        activator = 1'b1; tick();
        equalizer = 6'b00_00_11;
        repeat (64) press_release(3'b001);
        peek(2'd3);
        chk("sat_total", disp_s, 255);
        chk("wrap_total", disp_w, 0);
        chk("sat_ovf", ovf_s, 1);
        chk("wrap_ovf", ovf_w, 1);
        chk("sat_ind", ind_s, 10'h3FF);
        chk("wrap_ind", ind_w, 0);

        // Deactivation clears on the same edge
        activator = 1'b0; tick();
        chk("clr_disp", disp_s, 0);
        chk("clr_act", act_s, 0);
        chk("clr_ovf", ovf_s, 0);

        // Indicator thresholds around 50
        activator = 1'b1; tick();
        equalizer = 6'b00_00_11;
        repeat (12) press_release(3'b001);
        equalizer = 6'b00_00_00;
        press_release(3'b001);
        chk("ind_49", ind_s, 10'b0000000001);
        press_release(3'b001);
        chk("ind_50", ind_s, 10'b0000000011);

        // Button held across activator rise is not counted
        activator = 1'b0; buttons = 3'b001; tick();
        activator = 1'b1; tick();
        tick(); tick();
        chk("held_entry", disp_s, 0);
        chk("held_act", act_s, 1);

        // Reset mid-session
        buttons = 3'b000; tick();
        equalizer = 6'b00_10_00; press_release(3'b010);
        rst = 1'b1; tick();
        chk("midrst_disp", disp_s, 0);
        chk("midrst_act", act_s, 0);
        rst = 1'b0;

        // Randomized sessions
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (activator) activator = ($urandom_range(0, 99) != 0);
            else           activator = ($urandom_range(0, 99) < 30);
            buttons   = 3'($urandom);
            equalizer = 6'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/button_press_counter_n.md
Name: button_press_counter_n

Overview:
Parametrised N-channel successor to the fixed 3-button press counter. It detects rising edges on CHANNELS button inputs while the activator is high, and adds a per-press weight taken from the equalizer to a per-channel counter and to a total counter. Overflow is either saturating or wrapping. Drives a selectable display value and a thermometer indicator bar, and sits directly under the board top in place of the old counter core.

Parameters:
CHANNELS, 3, number of button inputs (1..8)
COUNT_W, 8, width of every counter and of display
WEIGHT_W, 2, equalizer field width per channel; increment = field + 1
IND_W, 10, indicator bar length
IND_STEP, 25, total-count units per indicator segment
SATURATE, 1, 1 = clamp counters at 2^COUNT_W-1; 0 = wrap modulo 2^COUNT_W

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
activator  in  1  high = counting session enabled; low = idle and cleared
buttons  in  CHANNELS  raw button levels, already synchronised upstream
equalizer  in  CHANNELS*WEIGHT_W  per-channel weight; field i = bits [i*WEIGHT_W +: WEIGHT_W]
view_sel  in  $clog2(CHANNELS+1)  0..CHANNELS-1 = show that channel; CHANNELS or above = show total
display  out  COUNT_W  selected counter value
indicator  out  IND_W  thermometer of total count
overflow  out  1  sticky; set when any counter clamps or wraps
active  out  1  high while FSM is in COUNT

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; all counters, btn_q and overflow cleared to 0. Resulting outputs: display=0, indicator=0, overflow=0, active=0. Reset mid-session aborts it immediately and has priority over everything.
- btn_q[i] registers buttons[i] every cycle in every state. press[i] = buttons[i] & ~btn_q[i].
- FSM states:
  - IDLE: counters and overflow held at 0. Moves to COUNT when activator=1.
  - COUNT: presses are counted. Moves to IDLE when activator=0; the clear takes effect on the same edge.
  - A button already held at session entry is not counted, because btn_q tracked it during IDLE.
- Latency: a press level present at edge t updates the counters at edge t. display and indicator reflect it immediately after edge t (one cycle after the level first appears before that edge).
- A held button counts once. It counts again only after a 0 is sampled.
- Increment: inc[i] = equalizer field i + 1, sampled in the press cycle. Width is WEIGHT_W+1.
- Per-channel counter: ch[i] += inc[i] on press[i].
- Total counter: total += sum of inc[i] over all pressed i. Simultaneous presses are all counted in one cycle, with a sum width of WEIGHT_W+1+clog2(CHANNELS).
- Overflow, evaluated independently for each counter at COUNT_W+1 bits:
  - SATURATE=1: result = 2^COUNT_W-1.
  - SATURATE=0: result = low COUNT_W bits.
  - In either mode overflow is set and stays set until IDLE or reset.
  - Total is an independent register, so it need not equal the sum of channel counters after saturation.
- display is a combinational mux of registers by view_sel; out-of-range view_sel shows total.
- indicator[k] = (total >= (k+1)*IND_STEP), combinational from the total register. Constant comparisons are sized to avoid truncation.
- active = (state == COUNT).

Decomposition:
- Shared include/package `bpc_defs`: FSM state encodings (IDLE=0, COUNT=1), an increment-width function and a clog2 function.
- One natural sub-module `bpc_channel`, instantiated CHANNELS times by generate. It contains btn_q, edge detect, the channel counter with saturate/wrap, and outputs press and inc.
- The top holds the FSM, the total adder tree, the sticky overflow flag, the view mux and the indicator comparators.

Test Plan (defaults):
- Reset then activator=1; press ch0 with eq0=0, ch1 with eq1=3 in separate pulses -> view_sel=0 shows 1, view_sel=1 shows 4, view_sel=3 shows 5, indicator=0, overflow=0.
- All three buttons rise together with eq=1,2,3 -> total +9 in one cycle; each channel gets +2/+3/+4.
- Hold ch2 high for 20 cycles, then release and press again with eq2=0 -> ch2 = 2 (counted once per rising edge).
- 64 presses of ch0 with eq=3 (4 each), SATURATE=1 -> total = 255, overflow=1, indicator=10'h3FF. With SATURATE=0 the same stimulus gives total = 0 (256 mod 256) and overflow=1.
- Total reaching 50 -> indicator=10'b0000000011; total 49 -> 10'b0000000001.
- Set activator=0 mid-session -> next cycle all counters 0, active=0, overflow=0.
- Button held across activator rise -> not counted.
- rst=1 during COUNT -> same clear as above.
